// File: rtl/axil_reg_pkg.sv
// ---------------------------------------------------------------------------
// axil_reg_pkg
// Shared definitions for the AXI4-Lite register responder:
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - NUM_REGS, the number of 32-bit control registers
//   - write and read FSM state encodings
//   - reg_onehot(): index to one-hot register select
// ---------------------------------------------------------------------------
package axil_reg_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int NUM_REGS = 4;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // One-hot select for a register index, used for the write pulses.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [1:0] idx);
        logic [NUM_REGS-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// ---------------------------------------------------------------------------
// axil_strb_merge
// Combinational byte-lane merge: each byte of the result comes from new_data
// when its strobe bit is set, otherwise from old_data.
// Ports:
//   old_data  in  DATA_WIDTH    current register value
//   new_data  in  DATA_WIDTH    write data
//   strb      in  DATA_WIDTH/8  byte strobes
//   merged    out DATA_WIDTH    value to commit
// ---------------------------------------------------------------------------
module axil_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = strb[gi] ? new_data[gi*8 +: 8] : old_data[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/axil_reg_responder.sv
// ---------------------------------------------------------------------------
// axil_reg_responder
// AXI4-Lite slave holding four 32-bit control registers at byte offsets
// 0x0/0x4/0x8/0xC (index = addr[3:2]). AW and W are captured independently
// into holding registers; the write commits on the edge after both are
// present. Reads return the register value sampled on the AR handshake edge,
// so a read colliding with a commit sees the pre-write value.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*       write address / data / response channels
//   S_AXI_AR*/R*          read address / data channels
//   reg_q                 packed register contents, reg0 in [31:0]
//   reg_wr_pulse          one-cycle pulse per register after its commit
//
// Build option:
//   AXIL_RESP_DECERR_EN   when defined, addresses with addr[ADDR_WIDTH-1:4]
//                         non-zero are unmapped: writes are dropped, reads
//                         return zero, both respond DECERR. When undefined,
//                         upper address bits alias onto the four registers.
// Only DATA_WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module axil_reg_responder
    import axil_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           ACLK,
    input  logic                           ARESET,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,

    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,

    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,

    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Goes high on the first edge after reset release; keeps every READY
    // low while reset is asserted even though the FSMs sit in idle.
    logic                               active_q, active_d;

    wr_state_t                          wr_state_q, wr_state_d;
    logic                               aw_flag_q, aw_flag_d;
    logic [ADDR_WIDTH-1:0]              aw_addr_q, aw_addr_d;
    logic                               w_flag_q, w_flag_d;
    logic [DATA_WIDTH-1:0]              w_data_q, w_data_d;
    logic [STRB_W-1:0]                  w_strb_q, w_strb_d;
    logic                               bvalid_q, bvalid_d;
    logic [1:0]                         bresp_q, bresp_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                pulse_q, pulse_d;

    rd_state_t                          rd_state_q, rd_state_d;
    logic                               rvalid_q, rvalid_d;
    logic [1:0]                         rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]              rdata_q, rdata_d;

    logic                               aw_hs, w_hs, ar_hs, commit;
    logic [1:0]                         wr_idx, rd_idx;
    logic                               wr_mapped, rd_mapped;
    logic [DATA_WIDTH-1:0]              merged;

    // Readies are functions of registered state only.
    assign S_AXI_AWREADY = active_q && (wr_state_q == W_IDLE) && !aw_flag_q;
    assign S_AXI_WREADY  = active_q && (wr_state_q == W_IDLE) && !w_flag_q;
    assign S_AXI_ARREADY = active_q && (rd_state_q == R_IDLE);

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (wr_state_q == W_IDLE) && aw_flag_q && w_flag_q;

    assign wr_idx = aw_addr_q[3:2];
    assign rd_idx = S_AXI_ARADDR[3:2];

`ifdef AXIL_RESP_DECERR_EN
    assign wr_mapped = (aw_addr_q[ADDR_WIDTH-1:4] == '0);
    assign rd_mapped = (S_AXI_ARADDR[ADDR_WIDTH-1:4] == '0);
`else
    assign wr_mapped = 1'b1;
    assign rd_mapped = 1'b1;
`endif

    // PROT and the byte-offset bits carry no meaning for this register file.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_q, S_AXI_ARADDR};

    axil_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .old_data (regs_q[wr_idx]),
        .new_data (w_data_q),
        .strb     (w_strb_q),
        .merged   (merged)
    );

    assign active_d = 1'b1;

    // Write FSM
    always_comb begin
        wr_state_d = wr_state_q;
        aw_flag_d  = aw_flag_q;
        aw_addr_d  = aw_addr_q;
        w_flag_d   = w_flag_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        pulse_d    = '0;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_flag_d = 1'b1;
                    aw_addr_d = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_flag_d = 1'b1;
                    w_data_d = S_AXI_WDATA;
                    w_strb_d = S_AXI_WSTRB;
                end
                // Readies are low once both flags are set, so a commit never
                // coincides with a new capture.
                if (commit) begin
                    aw_flag_d  = 1'b0;
                    w_flag_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    wr_state_d = W_RESP;
                    if (wr_mapped) begin
                        regs_d[wr_idx] = merged;
                        pulse_d        = reg_onehot(wr_idx);
                        bresp_d        = AXI_RESP_OKAY;
                    end else begin
                        bresp_d        = AXI_RESP_DECERR;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read FSM
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                    if (rd_mapped) begin
                        rdata_d = regs_q[rd_idx];
                        rresp_d = AXI_RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = AXI_RESP_DECERR;
                    end
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            active_q   <= 1'b0;
            wr_state_q <= W_IDLE;
            aw_flag_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_flag_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXI_RESP_OKAY;
            regs_q     <= '0;
            pulse_q    <= '0;
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            active_q   <= active_d;
            wr_state_q <= wr_state_d;
            aw_flag_q  <= aw_flag_d;
            aw_addr_q  <= aw_addr_d;
            w_flag_q   <= w_flag_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            pulse_q    <= pulse_d;
            rd_state_q <= rd_state_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign reg_q        = regs_q;
    assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_responder
// Directed bench for axil_reg_responder. Stimulus tasks push the expected
// B response, R response and write pulse into queues; independent monitors
// pop and compare whenever the DUT completes a B or R handshake or raises a
// write pulse. Timing-specific behaviour (reset, skew, backpressure) is
// checked inline at the falling edge.
// ---------------------------------------------------------------------------
module tb_axil_reg_responder;

    logic         ACLK;
    logic         ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    axil_reg_responder #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];   // {rresp, rdata}
    logic [3:0]  p_exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- monitors ----------------
    always @(negedge ACLK) begin : mon_b
        logic [1:0] e;
        if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
            if (b_exp_q.size() == 0) begin
                fail("b_unexpected");
            end else begin
                e = b_exp_q.pop_front();
                check("bresp", {126'd0, S_AXI_BRESP}, {126'd0, e});
                $display("B  resp=%0d exp=%0d", S_AXI_BRESP, e);
            end
        end
    end

    always @(negedge ACLK) begin : mon_r
        logic [33:0] e;
        if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
            if (r_exp_q.size() == 0) begin
                fail("r_unexpected");
            end else begin
                e = r_exp_q.pop_front();
                check("rdata_rresp", {94'd0, S_AXI_RRESP, S_AXI_RDATA}, {94'd0, e});
                $display("R  data=0x%08h resp=%0d exp data=0x%08h resp=%0d",
                         S_AXI_RDATA, S_AXI_RRESP, e[31:0], e[33:32]);
            end
        end
    end

    always @(negedge ACLK) begin : mon_p
        logic [3:0] e;
        if (!ARESET && reg_wr_pulse != 4'b0) begin
            if (p_exp_q.size() == 0) begin
                check("pulse_unexpected", {124'd0, reg_wr_pulse}, 128'd0);
            end else begin
                e = p_exp_q.pop_front();
                check("wr_pulse", {124'd0, reg_wr_pulse}, {124'd0, e});
                $display("P  pulse=%b exp=%b", reg_wr_pulse, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_aw(input logic [5:0] addr);
        int  n    = 0;
        bit  done = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge ACLK);
            done = S_AXI_AWREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        if (!done) fail("aw_accept");
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
        int  n    = 0;
        bit  done = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge ACLK);
            done = S_AXI_WREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        S_AXI_WVALID = 1'b0;
        if (!done) fail("w_accept");
    endtask

    task automatic drive_ar(input logic [5:0] addr);
        int  n    = 0;
        bit  done = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge ACLK);
            done = S_AXI_ARREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!done) fail("ar_accept");
    endtask

    task automatic wait_b();
        int n    = 0;
        bit done = 0;
        while (!done && n < 50) begin
            @(negedge ACLK);
            done = S_AXI_BVALID && S_AXI_BREADY;
            n++;
        end
        @(posedge ACLK);
        #1;
        if (!done) fail("b_handshake");
    endtask

    task automatic wait_r();
        int n    = 0;
        bit done = 0;
        while (!done && n < 50) begin
            @(negedge ACLK);
            done = S_AXI_RVALID && S_AXI_RREADY;
            n++;
        end
        @(posedge ACLK);
        #1;
        if (!done) fail("r_handshake");
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input logic [3:0] exp_pulse);
        b_exp_q.push_back(exp_resp);
        if (exp_pulse != 4'b0) p_exp_q.push_back(exp_pulse);
        fork
            drive_aw(addr);
            drive_w(data, strb);
        join
        wait_b();
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        r_exp_q.push_back({exp_resp, exp_data});
        drive_ar(addr);
        wait_r();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] exp_reg0;

    initial begin : stim
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;

        // Reset state
        repeat (2) @(negedge ACLK);
        check("rst_readies", {125'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 128'd0);
        check("rst_valids_resps", {122'd0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 128'd0);
        check("rst_rdata", {96'd0, S_AXI_RDATA}, 128'd0);
        check("rst_reg_q", reg_q, 128'd0);
        check("rst_pulse", {124'd0, reg_wr_pulse}, 128'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("ready_low_before_first_edge", {127'd0, S_AXI_AWREADY}, 128'd0);
        @(negedge ACLK);
        check("readies_up", {125'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 128'd7);
        @(posedge ACLK);
        #1;

        // Sequential write / read-back
        do_write(6'h00, 32'h1, 4'hF, OKAY, 4'b0001);
        do_write(6'h04, 32'h2, 4'hF, OKAY, 4'b0010);
        do_write(6'h08, 32'h3, 4'hF, OKAY, 4'b0100);
        do_write(6'h0C, 32'h4, 4'hF, OKAY, 4'b1000);
        do_read(6'h00, 32'h1, OKAY);
        do_read(6'h04, 32'h2, OKAY);
        do_read(6'h08, 32'h3, OKAY);
        do_read(6'h0C, 32'h4, OKAY);
        check("seq_reg_q", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});

        // Byte strobes
        do_write(6'h04, 32'hAABBCCDD, 4'hF, OKAY, 4'b0010);
        do_write(6'h04, 32'h11223344, 4'h5, OKAY, 4'b0010);
        do_read(6'h04, 32'hAA22CC44, OKAY);

        // Skew: AW first, W five cycles later
        b_exp_q.push_back(OKAY);
        p_exp_q.push_back(4'b0100);
        drive_aw(6'h08);
        @(negedge ACLK);
        check("skew_awready_dropped", {127'd0, S_AXI_AWREADY}, 128'd0);
        check("skew_wready_still_up", {127'd0, S_AXI_WREADY}, 128'd1);
        repeat (4) @(posedge ACLK);
        #1;
        check("skew_no_early_b", {127'd0, S_AXI_BVALID}, 128'd0);
        drive_w(32'hCAFE0001, 4'hF);
        @(negedge ACLK);
        check("skew_aw_b_not_early", {127'd0, S_AXI_BVALID}, 128'd0);
        @(negedge ACLK);
        check("skew_aw_b_on_time", {127'd0, S_AXI_BVALID}, 128'd1);
        @(posedge ACLK);
        #1;

        // Skew: W first, AW three cycles later
        b_exp_q.push_back(OKAY);
        p_exp_q.push_back(4'b1000);
        drive_w(32'h0BADF00D, 4'hF);
        @(negedge ACLK);
        check("skew_wready_dropped", {127'd0, S_AXI_WREADY}, 128'd0);
        check("skew_awready_still_up", {127'd0, S_AXI_AWREADY}, 128'd1);
        repeat (2) @(posedge ACLK);
        #1;
        drive_aw(6'h0C);
        @(negedge ACLK);
        check("skew_w_b_not_early", {127'd0, S_AXI_BVALID}, 128'd0);
        @(negedge ACLK);
        check("skew_w_b_on_time", {127'd0, S_AXI_BVALID}, 128'd1);
        @(posedge ACLK);
        #1;
        do_read(6'h08, 32'hCAFE0001, OKAY);
        do_read(6'h0C, 32'h0BADF00D, OKAY);

        // Backpressure on both response channels
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        b_exp_q.push_back(OKAY);
        p_exp_q.push_back(4'b0001);
        r_exp_q.push_back({OKAY, 32'hAA22CC44});
        fork
            drive_aw(6'h00);
            drive_w(32'h12345678, 4'hF);
            drive_ar(6'h04);
        join
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            check("bp_b_hold", {123'd0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY},
                  {123'd0, 1'b1, OKAY, 1'b0, 1'b0});
            check("bp_r_hold", {93'd0, S_AXI_RVALID, S_AXI_RRESP, S_AXI_ARREADY, S_AXI_RDATA},
                  {93'd0, 1'b1, OKAY, 1'b0, 32'hAA22CC44});
        end
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        fork
            wait_b();
            wait_r();
        join

        // Collision: AR to reg2 on the commit edge of a write
        do_write(6'h08, 32'h33, 4'hF, OKAY, 4'b0100);
        b_exp_q.push_back(OKAY);
        p_exp_q.push_back(4'b0100);
        r_exp_q.push_back({OKAY, 32'h33});
        fork
            begin
                drive_aw(6'h08);
            end
            begin
                drive_w(32'h55, 4'hF);
            end
            begin
                // AW/W captured at the first edge; commit is the next one.
                @(posedge ACLK);
                #1;
                S_AXI_ARADDR  = 6'h08;
                S_AXI_ARVALID = 1'b1;
                @(negedge ACLK);
                check("coll_arready", {127'd0, S_AXI_ARREADY}, 128'd1);
                check("coll_commit_pending", {127'd0, S_AXI_BVALID}, 128'd0);
                @(posedge ACLK);
                #1;
                S_AXI_ARVALID = 1'b0;
            end
        join
        fork
            wait_b();
            wait_r();
        join
        do_read(6'h08, 32'h55, OKAY);

        // Address above the register window
`ifdef AXIL_RESP_DECERR_EN
        do_write(6'h10, 32'hFFFF, 4'hF, DECERR, 4'b0000);
        do_read(6'h10, 32'h0, DECERR);
        exp_reg0 = 32'h12345678;
`else
        do_write(6'h10, 32'hFFFF, 4'hF, OKAY, 4'b0001);
        do_read(6'h10, 32'hFFFF, OKAY);
        exp_reg0 = 32'h0000FFFF;
`endif
        check("upper_addr_reg_q", reg_q, {32'h0BADF00D, 32'h55, 32'hAA22CC44, exp_reg0});

        // Reset with a write half-captured
        drive_aw(6'h04);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("midrst_readies_valids",
              {123'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 128'd0);
        check("midrst_reg_q", reg_q, 128'd0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        do_write(6'h04, 32'h9, 4'hF, OKAY, 4'b0010);
        do_read(6'h04, 32'h9, OKAY);
        check("post_rst_reg_q", reg_q, {32'h0, 32'h0, 32'h9, 32'h0});

        repeat (3) @(posedge ACLK);
        check("b_queue_drained", {96'd0, b_exp_q.size()}, 128'd0);
        check("r_queue_drained", {96'd0, r_exp_q.size()}, 128'd0);
        check("p_queue_drained", {96'd0, p_exp_q.size()}, 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
